// File: rtl/regfile_pkg.sv
// Shared types and default widths for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/rf_init_ctrl.sv
// Initialisation sequencer: sweeps every entry once after reset, then holds RUN.
module rf_init_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              ready,
  output rf_state_t         state
);

  localparam int DEPTH = 1 << ADDR_W;
  // One extra bit so the counter cannot wrap to 0 before the RUN transition.
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  logic [ADDR_W:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign init_we   = (state == INIT);
  assign init_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/regfile_param.sv
// Register file, 2 async read ports, 1 sync write port, self-initialising.
// Optional same-cycle write-to-read forwarding under macro RF_BYPASS_EN.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              ready,
  output logic              wr_reject
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  rf_state_t         init_state;
  logic              wr_zero;

  rf_init_ctrl #(.ADDR_W(ADDR_W)) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .ready     (ready),
    .state     (init_state)
  );

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

  // The sequencer owns the write port during INIT; external writes only in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we) begin
        mem[init_addr] <= INIT_VAL;
      end else if (we && !wr_zero) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_reject <= 1'b0;
    end else begin
      wr_reject <= we && (init_state == INIT);
    end
  end

  always_comb begin
    rd_data1 = '0;
    if (ready && !((ZERO_REG != 0) && (rd_addr1 == '0))) begin
      rd_data1 = mem[rd_addr1];
`ifdef RF_BYPASS_EN
      if (we && !wr_zero && (wr_addr == rd_addr1)) begin
        rd_data1 = wr_data;
      end
`endif
    end
  end

  always_comb begin
    rd_data2 = '0;
    if (ready && !((ZERO_REG != 0) && (rd_addr2 == '0))) begin
      rd_data2 = mem[rd_addr2];
`ifdef RF_BYPASS_EN
      if (we && !wr_zero && (wr_addr == rd_addr2)) begin
        rd_data2 = wr_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed + random bench for regfile_param with a scoreboard expectation queue.
module tb_regfile_param;
  localparam int W = 32;
  localparam int AW = 5;
  localparam logic [W-1:0] IV = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          rst, we;
  logic [AW-1:0] wr_addr, rd_addr1, rd_addr2;
  logic [W-1:0]  wr_data, rd_data1, rd_data2;
  logic          ready, wr_reject;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  model [32];
  int            errors = 0;
  int            checks = 0;

  regfile_param #(.ADDR_W(AW), .DATA_W(W), .INIT_VAL(IV), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1),
    .rd_data2(rd_data2), .ready(ready), .wr_reject(wr_reject)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    step();
    we = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = 5'd5; rd_addr2 = '0;
    repeat (2) step();
    push(0); check("reset_ready", {31'd0, ready});
    push(0); check("reset_rd1", rd_data1);
    push(0); check("reset_reject", {31'd0, wr_reject});

    // Init sweep with a write attempt landing on edge 10.
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      push((i == 32) ? 1 : 0); check($sformatf("sweep_ready_e%0d", i), {31'd0, ready});
      push((i == 32) ? IV : 0); check($sformatf("sweep_rd5_e%0d", i), rd_data1);
      push((i == 10) ? 1 : 0); check($sformatf("sweep_reject_e%0d", i), {31'd0, wr_reject});
      if (i == 9) begin we = 1'b1; wr_addr = 5'd7; wr_data = 32'hFF; end
      if (i == 10) we = 1'b0;
    end

    for (int a = 0; a < 32; a++) model[a] = (a == 0) ? '0 : IV;
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a); rd_addr2 = 5'(a); #1;
      push(model[a]); check($sformatf("init_rd1_r%0d", a), rd_data1);
      push(model[a]); check($sformatf("init_rd2_r%0d", a), rd_data2);
    end

    // Basic write/read.
    wr(5'd3, 32'h4);
    rd_addr1 = 5'd3; #1;
    push(32'h4); check("wr_r3", rd_data1);
    wr(5'd31, 32'hDEADBEEF);
    rd_addr2 = 5'd31; #1;
    push(32'hDEADBEEF); check("wr_r31", rd_data2);

    // Zero register: dropped write, no reject.
    rd_addr1 = 5'd0; we = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; #1;
    push(0); check("r0_before", rd_data1);
    step();
    we = 1'b0;
    push(0); check("r0_after", rd_data1);
    push(0); check("r0_reject", {31'd0, wr_reject});

    // Same-cycle read/write of r4.
    wr(5'd4, 32'h2);
    rd_addr1 = 5'd4; rd_addr2 = 5'd4;
    we = 1'b1; wr_addr = 5'd4; wr_data = 32'h9; #1;
`ifdef RF_BYPASS_EN
    push(32'h9); push(32'h9);
`else
    push(32'h2); push(32'h2);
`endif
    check("same_cycle_rd1", rd_data1);
    check("same_cycle_rd2", rd_data2);
    step();
    we = 1'b0;
    model[4] = 32'h9;
    push(32'h9); check("next_cycle_rd1", rd_data1);

    // Random writes, then full readback against the model.
    for (int n = 0; n < 40; n++) begin
      wr(5'($urandom_range(0, 31)), $urandom);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a); rd_addr2 = 5'(31 - a); #1;
      push(model[a]); check($sformatf("rand_rd1_r%0d", a), rd_data1);
      push(model[31 - a]); check($sformatf("rand_rd2_r%0d", 31 - a), rd_data2);
    end

    // Reset in the middle of a second sweep.
    wr(5'd2, 32'h3);
    rd_addr1 = 5'd2; #1;
    push(32'h3); check("r2_written", rd_data1);
    rst = 1'b1; step(); rst = 1'b0;
    repeat (15) step();
    push(0); check("sweep2_cnt15_ready", {31'd0, ready});
    rst = 1'b1; step(); rst = 1'b0;
    push(0); check("midreset_ready", {31'd0, ready});
    for (int i = 1; i <= 32; i++) begin
      step();
      push((i == 32) ? 1 : 0); check($sformatf("sweep3_ready_e%0d", i), {31'd0, ready});
    end
    push(IV); check("r2_reinit", rd_data1);

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $error("FAIL leftover_expectations: observed %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
